a_reg_loader: RTL and testbench
===============================

// Module: a_reg_loader
// PURPOSE
//   Consumer end of the Amux path: owns the CPU accumulator register A.
//   On request from the control unit it drives A_select, waits for the mux to settle, captures
//   the mux output into A and acknowledges the request.
//   It updates Z/N flags and offers each new A value to a downstream reader over a valid/ready port.
// PARAMETERS
//   WIDTH          8   data width of A, mux_op and rd_data
//   SETTLE_CYCLES  1   cycles A_select is held before mux_op is sampled (legal 1..15)
// PORTS
//   clk         in   1      rising-edge clock; only clock
//   rst         in   1      synchronous, active-high reset
//   load_req    in   1      request to load A; sampled only in IDLE
//   load_src    in   1      source for the load: 0 = d0 path, 1 = d1 path
//   A_select    out  1      select to the Amux
//   mux_op      in   WIDTH  Amux op output
//   load_ack    out  1      one-cycle pulse: A has been updated
//   busy        out  1      high in every state except IDLE
//   a_q         out  WIDTH  current contents of A
//   a_zero      out  1      a_q == 0
//   a_neg       out  1      a_q[WIDTH-1]
//   rd_valid    out  1      rd_data holds an unconsumed A value
//   rd_ready    in   1      downstream accepts rd_data
//   rd_data     out  WIDTH  copy of A offered downstream
//   rd_overrun  out  1      sticky: a new A value replaced an unconsumed one
// BEHAVIOUR
//   - Reset (synchronous, active-high, any state):
//     - State goes to IDLE.
//     - A_select, load_ack, a_q, rd_valid, rd_data and rd_overrun all go to 0.
//     - a_zero goes to 1 and a_neg to 0; a_zero and a_neg follow a_q combinationally.
//     - Reset aborts any load in flight; no ack is issued.
//   - FSM states: IDLE, SETTLE, CAPTURE, DONE.
//     - IDLE -> SETTLE at edge N when load_req=1:
//       - A_select <= load_src.
//       - The settle counter loads SETTLE_CYCLES-1.
//     - SETTLE: the counter decrements each edge; at 0 go to CAPTURE. Duration is SETTLE_CYCLES cycles.
//     - CAPTURE -> DONE:
//       - a_q <= mux_op.
//       - load_ack <= 1.
//     - DONE -> IDLE: load_ack <= 0. load_req seen in DONE is ignored.
//   - Latency:
//     - a_q and load_ack change at edge N+SETTLE_CYCLES+1.
//     - load_ack is high for exactly 1 cycle.
//     - Minimum interval between accepted requests is SETTLE_CYCLES+3 cycles.
//   - A_select holds its last value after DONE; it changes only on acceptance or reset.
//   - load_req and load_src are ignored while busy.
//   - Read port, evaluated at the same edge as CAPTURE:
//     - On CAPTURE, rd_data <= mux_op and rd_valid <= 1.
//     - If rd_valid=1 and rd_ready=0 at that edge, rd_overrun <= 1.
//     - If rd_valid=1 and rd_ready=1 at that edge, the old value is consumed; this is not an overrun.
//     - Outside CAPTURE, rd_valid=1 and rd_ready=1 -> rd_valid <= 0 and rd_data holds.
//     - rd_data is stable while rd_valid=1 and rd_ready=0, except when overwritten by CAPTURE.
//     - rd_ready is ignored while rd_valid=0.
//     - rd_overrun clears only on reset.
// TESTING
//   1. Reset: assert rst 2 cycles -> a_q=0, a_zero=1, A_select=0, rd_valid=0, busy=0, rd_overrun=0.
//   2. Load from d1:
//      - Stimulus: mux_op=6, load_src=1, load_req pulse at edge N (SETTLE_CYCLES=1).
//      - Response: A_select=1 after N; a_q=6 and load_ack=1 after edge N+2; rd_valid=1; rd_data=6.
//      - Response: ack low after N+3, busy low after N+3.
//   3. Flags:
//      - load mux_op=0x00 -> a_zero=1, a_neg=0.
//      - load mux_op=0x80 -> a_zero=0, a_neg=1.
//      - load mux_op=9 -> both 0.
//   4. Read handshake and overrun:
//      - Stimulus: load 9 with rd_ready=0, then load 6 with rd_ready=0.
//      - Response: rd_data=6, rd_overrun=1.
//      - Then rd_ready=1 for one cycle -> rd_valid=0.
//   5. Busy and mid-operation reset:
//      - load_req held high through a load -> the next request is accepted only at the DONE+1 edge.
//      - rst during SETTLE -> state IDLE, a_q unchanged from reset value 0, no load_ack.
//   6. SETTLE_CYCLES=4 instance: load_req at edge N -> a_q updates at edge N+5, not earlier.

Source files
------------

// File: rtl/a_reg_loader.sv
// rtl/a_reg_loader.sv - accumulator A loader: selects Amux source, waits for settle, captures, publishes
module a_reg_loader #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    input  logic             load_src,
    output logic             A_select,
    input  logic [WIDTH-1:0] mux_op,
    output logic             load_ack,
    output logic             busy,
    output logic [WIDTH-1:0] a_q,
    output logic             a_zero,
    output logic             a_neg,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; requests are only looked at while idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_req) state_next = SETTLE;
            SETTLE:  if (settle_cnt == 4'd0) state_next = CAPTURE;
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the mux select on acceptance and count down the settle window.
    always_ff @(posedge clk) begin
        if (rst) begin
            A_select   <= 1'b0;
            settle_cnt <= 4'd0;
        end else if (state == IDLE && load_req) begin
            A_select   <= load_src;
            settle_cnt <= 4'(SETTLE_CYCLES - 1);
        end else if (state == SETTLE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Capture the settled mux output into A; ack is high exactly while in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= (state == CAPTURE);
            if (state == CAPTURE) begin
                a_q <= mux_op;
            end
        end
    end

    // Downstream copy of A; a capture over an unconsumed value sets the sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_overrun <= 1'b0;
        end else if (state == CAPTURE) begin
            rd_data  <= mux_op;
            rd_valid <= 1'b1;
            if (rd_valid && !rd_ready) begin
                rd_overrun <= 1'b1;
            end
        end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

    assign busy   = (state != IDLE);
    assign a_zero = (a_q == '0);
    assign a_neg  = a_q[WIDTH-1];

endmodule

// File: tb/tb_a_reg_loader.sv
// tb/tb_a_reg_loader.sv - randomized model-checked bench for a_reg_loader (settle 1 and settle 4)
module tb_a_reg_loader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_req = 1'b0;
    logic         load_src = 1'b0;
    logic [W-1:0] mux_op = '0;
    logic         rd_ready = 1'b0;

    logic         asel_o  [2];
    logic         ack_o   [2];
    logic         busy_o  [2];
    logic [W-1:0] aq_o    [2];
    logic         zero_o  [2];
    logic         neg_o   [2];
    logic         rv_o    [2];
    logic [W-1:0] rd_o    [2];
    logic         ovr_o   [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    a_reg_loader #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .load_req(load_req), .load_src(load_src),
        .A_select(asel_o[0]), .mux_op(mux_op), .load_ack(ack_o[0]), .busy(busy_o[0]),
        .a_q(aq_o[0]), .a_zero(zero_o[0]), .a_neg(neg_o[0]), .rd_valid(rv_o[0]),
        .rd_ready(rd_ready), .rd_data(rd_o[0]), .rd_overrun(ovr_o[0])
    );

    a_reg_loader #(.WIDTH(W), .SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .load_req(load_req), .load_src(load_src),
        .A_select(asel_o[1]), .mux_op(mux_op), .load_ack(ack_o[1]), .busy(busy_o[1]),
        .a_q(aq_o[1]), .a_zero(zero_o[1]), .a_neg(neg_o[1]), .rd_valid(rv_o[1]),
        .rd_ready(rd_ready), .rd_data(rd_o[1]), .rd_overrun(ovr_o[1])
    );

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, inst, $time, act, exp);
        end
    endtask

    // Reference: t counts edges since the request was accepted (-1 = idle).
    // Capture happens at edge S+1 after acceptance, the unit is idle again at S+2.
    int           m_t   [2];
    logic         m_asel[2];
    logic         m_ack [2];
    logic [W-1:0] m_a   [2];
    logic         m_rv  [2];
    logic [W-1:0] m_rd  [2];
    logic         m_ovr [2];
    bit           model_on = 1'b0;

    always @(posedge clk) begin
        logic         s_rst, s_req, s_src, s_rdy;
        logic [W-1:0] s_mux;
        s_rst = rst; s_req = load_req; s_src = load_src; s_rdy = rd_ready; s_mux = mux_op;
        for (int i = 0; i < 2; i++) begin
            int  s;
            bit  cap;
            s   = (i == 0) ? 1 : 4;
            cap = 1'b0;
            if (s_rst) begin
                m_t[i] = -1; m_asel[i] = 1'b0; m_ack[i] = 1'b0; m_a[i] = '0;
                m_rv[i] = 1'b0; m_rd[i] = '0; m_ovr[i] = 1'b0;
            end else begin
                m_ack[i] = 1'b0;
                if (m_t[i] < 0) begin
                    if (s_req) begin
                        m_asel[i] = s_src;
                        m_t[i] = 0;
                    end
                end else begin
                    m_t[i] = m_t[i] + 1;
                    if (m_t[i] == s + 1) cap = 1'b1;
                    else if (m_t[i] == s + 2) m_t[i] = -1;
                end
                if (cap) begin
                    m_a[i] = s_mux;
                    m_ack[i] = 1'b1;
                    if (m_rv[i] && !s_rdy) m_ovr[i] = 1'b1;
                    m_rv[i] = 1'b1;
                    m_rd[i] = s_mux;
                end else if (m_rv[i] && s_rdy) begin
                    m_rv[i] = 1'b0;
                end
            end
        end
        if (s_rst) model_on = 1'b1;
        #1;
        if (model_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("A_select", i, 32'(asel_o[i]), 32'(m_asel[i]));
                chk("load_ack", i, 32'(ack_o[i]),  32'(m_ack[i]));
                chk("busy",     i, 32'(busy_o[i]), 32'(m_t[i] >= 0));
                chk("a_q",      i, 32'(aq_o[i]),   32'(m_a[i]));
                chk("a_zero",   i, 32'(zero_o[i]), 32'(m_a[i] == 0));
                chk("a_neg",    i, 32'(neg_o[i]),  32'(m_a[i][W-1]));
                chk("rd_valid", i, 32'(rv_o[i]),   32'(m_rv[i]));
                chk("rd_data",  i, 32'(rd_o[i]),   32'(m_rd[i]));
                chk("rd_overrun", i, 32'(ovr_o[i]), 32'(m_ovr[i]));
            end
        end
    end

    task automatic do_load(input logic [W-1:0] val, input logic src);
        mux_op = val; load_src = src; load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_a_q", 0, 32'(aq_o[0]), 32'h0);
        chk("rst_a_zero", 0, 32'(zero_o[0]), 32'h1);
        chk("rst_A_select", 0, 32'(asel_o[0]), 32'h0);
        chk("rst_rd_valid", 0, 32'(rv_o[0]), 32'h0);
        chk("rst_busy", 0, 32'(busy_o[0]), 32'h0);
        chk("rst_overrun", 0, 32'(ovr_o[0]), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Load 6 from d1; settle 1 captures at N+2, settle 4 at N+5
        mux_op = 8'd6; load_src = 1'b1; load_req = 1'b1; rd_ready = 1'b0;
        @(negedge clk);
        load_req = 1'b0;
        chk("sel_after_N", 0, 32'(asel_o[0]), 32'h1);
        @(negedge clk);
        chk("a_q_N1", 0, 32'(aq_o[0]), 32'h0);
        chk("ack_N1", 0, 32'(ack_o[0]), 32'h0);
        @(negedge clk);
        chk("a_q_N2", 0, 32'(aq_o[0]), 32'h6);
        chk("ack_N2", 0, 32'(ack_o[0]), 32'h1);
        chk("rd_valid_N2", 0, 32'(rv_o[0]), 32'h1);
        chk("rd_data_N2", 0, 32'(rd_o[0]), 32'h6);
        @(negedge clk);
        chk("ack_N3", 0, 32'(ack_o[0]), 32'h0);
        chk("busy_N3", 0, 32'(busy_o[0]), 32'h0);
        @(negedge clk);
        chk("s4_a_q_N4", 1, 32'(aq_o[1]), 32'h0);
        @(negedge clk);
        chk("s4_a_q_N5", 1, 32'(aq_o[1]), 32'h6);
        chk("s4_ack_N5", 1, 32'(ack_o[1]), 32'h1);
        repeat (3) @(negedge clk);

        // Overrun: two loads without consuming
        do_load(8'd9, 1'b0);
        do_load(8'd6, 1'b1);
        chk("ovr_rd_data", 0, 32'(rd_o[0]), 32'h6);
        chk("ovr_flag", 0, 32'(ovr_o[0]), 32'h1);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("consume_rd_valid", 0, 32'(rv_o[0]), 32'h0);
        chk("consume_ovr_sticky", 0, 32'(ovr_o[0]), 32'h1);

        // Flags
        do_load(8'h00, 1'b0);
        chk("z_00", 0, 32'(zero_o[0]), 32'h1);
        chk("n_00", 0, 32'(neg_o[0]), 32'h0);
        do_load(8'h80, 1'b1);
        chk("z_80", 0, 32'(zero_o[0]), 32'h0);
        chk("n_80", 0, 32'(neg_o[0]), 32'h1);
        do_load(8'h09, 1'b0);
        chk("z_09", 0, 32'(zero_o[0]), 32'h0);
        chk("n_09", 0, 32'(neg_o[0]), 32'h0);

        // load_req held high: next acceptance four edges after the first
        mux_op = 8'h33; load_req = 1'b1;
        @(negedge clk);
        chk("held_busy_M", 0, 32'(busy_o[0]), 32'h1);
        repeat (3) @(negedge clk);
        chk("held_busy_M3", 0, 32'(busy_o[0]), 32'h0);
        @(negedge clk);
        chk("held_busy_M4", 0, 32'(busy_o[0]), 32'h1);
        load_req = 1'b0;
        repeat (8) @(negedge clk);

        // Reset in the middle of a load
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mux_op = 8'h5A; load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 0, 32'(busy_o[0]), 32'h0);
        chk("midrst_busy", 1, 32'(busy_o[1]), 32'h0);
        repeat (8) @(negedge clk);
        chk("midrst_a_q", 0, 32'(aq_o[0]), 32'h0);
        chk("midrst_a_q", 1, 32'(aq_o[1]), 32'h0);

        // Randomized traffic against the reference
        repeat (3000) begin
            load_req = ($urandom_range(0, 9) < 3);
            load_src = 1'($urandom);
            mux_op   = W'($urandom);
            rd_ready = ($urandom_range(0, 1) == 1);
            rst      = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        load_req = 1'b0; rst = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
